// File: rtl/cv32e40p_instr_aligner_if.sv
// Handshake bundle between prefetch FIFO, instruction aligner and decode.
interface cv32e40p_instr_aligner_if;
  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic        fetch_ready_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic        instr_compressed_o;
  logic [31:0] pc_o;
  logic        branch_i;
  logic [31:0] branch_addr_i;

  modport slave (
    input  fetch_valid_i, fetch_rdata_i, instr_ready_i, branch_i, branch_addr_i,
    output fetch_ready_o, instr_valid_o, instr_o, instr_compressed_o, pc_o
  );

  modport master (
    output fetch_valid_i, fetch_rdata_i, instr_ready_i, branch_i, branch_addr_i,
    input  fetch_ready_o, instr_valid_o, instr_o, instr_compressed_o, pc_o
  );
endinterface

// File: rtl/cv32e40p_instr_aligner.sv
// Instruction aligner: splits 32-bit fetch words into 16/32-bit instructions,
// reassembling 32-bit instructions that straddle a word boundary.
module cv32e40p_instr_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0080
) (
  input logic                       clk_i,
  input logic                       rst_ni,
  cv32e40p_instr_aligner_if.slave   bus
);

  localparam logic [1:0] ALIGNED = 2'd0;
  localparam logic [1:0] MIS32   = 2'd1;
  localparam logic [1:0] MIS16   = 2'd2;
  localparam logic [1:0] BR_MIS  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] half_q, half_d;
  logic [31:0] pc_q, pc_d;

  logic [31:0] w;
  logic        fv;
  logic        valid;
  logic        fready;
  logic [31:0] instr;
  logic        comp;
  logic        unused_addr_bit0;

  assign w  = bus.fetch_rdata_i;
  assign fv = bus.fetch_valid_i;
  assign unused_addr_bit0 = bus.branch_addr_i[0];

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    pc_d    = pc_q;
    valid   = 1'b0;
    fready  = 1'b0;
    instr   = w;
    comp    = 1'b0;

    case (state_q)
      ALIGNED: begin
        valid = fv;
        if (w[1:0] == 2'b11) begin
          instr = w;
          comp  = 1'b0;
          if (fv && bus.instr_ready_i) begin
            fready = 1'b1;
            pc_d   = pc_q + 32'd4;
          end
        end else begin
          instr = {16'h0000, w[15:0]};
          comp  = 1'b1;
          if (fv && bus.instr_ready_i) begin
            fready  = 1'b1;
            half_d  = w[31:16];
            pc_d    = pc_q + 32'd2;
            state_d = (w[17:16] == 2'b11) ? MIS32 : MIS16;
          end
        end
      end
      MIS32: begin
        valid = fv;
        instr = {w[15:0], half_q};
        comp  = 1'b0;
        if (fv && bus.instr_ready_i) begin
          fready  = 1'b1;
          half_d  = w[31:16];
          pc_d    = pc_q + 32'd4;
          state_d = (w[17:16] == 2'b11) ? MIS32 : MIS16;
        end
      end
      MIS16: begin
        // Served entirely from half_q, so the FIFO head is irrelevant here.
        valid = 1'b1;
        instr = {16'h0000, half_q};
        comp  = 1'b1;
        if (bus.instr_ready_i) begin
          pc_d    = pc_q + 32'd2;
          state_d = ALIGNED;
        end
      end
      default: begin
        // BR_MIS: drop the lower halfword that precedes the branch target.
        if (fv) begin
          fready  = 1'b1;
          half_d  = w[31:16];
          state_d = (w[17:16] == 2'b11) ? MIS32 : MIS16;
        end
      end
    endcase

    if (bus.branch_i) begin
      valid   = 1'b0;
      fready  = 1'b0;
      half_d  = half_q;
      pc_d    = {bus.branch_addr_i[31:1], 1'b0};
      state_d = bus.branch_addr_i[1] ? BR_MIS : ALIGNED;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ALIGNED;
      half_q  <= '0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.instr_valid_o      = valid;
  assign bus.fetch_ready_o      = fready;
  assign bus.instr_o            = instr;
  assign bus.instr_compressed_o = comp;
  assign bus.pc_o               = pc_q;

endmodule

// File: tb/tb_cv32e40p_instr_aligner.sv
// Directed, table-driven bench for cv32e40p_instr_aligner.
module tb_cv32e40p_instr_aligner;

  logic clk;
  logic rst_n;

  cv32e40p_instr_aligner_if bus ();

  cv32e40p_instr_aligner #(.RESET_PC(32'h0000_0080)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [31:0] rdata;
    logic        rdy;
    logic        br;
    logic [31:0] baddr;
    logic        e_valid;
    logic        e_fready;
    logic [31:0] e_instr;
    logic        e_comp;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   failures;

  function automatic vec_t mk(input logic fv, input logic [31:0] rdata, input logic rdy,
                              input logic br, input logic [31:0] baddr,
                              input logic ev, input logic ef, input logic [31:0] ei,
                              input logic ec, input logic [31:0] ep);
    vec_t v;
    v.fv = fv; v.rdata = rdata; v.rdy = rdy; v.br = br; v.baddr = baddr;
    v.e_valid = ev; v.e_fready = ef; v.e_instr = ei; v.e_comp = ec; v.e_pc = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [31:0] rdata, input logic rdy,
                       input logic br, input logic [31:0] baddr);
    bus.fetch_valid_i = fv;
    bus.fetch_rdata_i = rdata;
    bus.instr_ready_i = rdy;
    bus.branch_i      = br;
    bus.branch_addr_i = baddr;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    //            fv  rdata          rdy br  baddr          valid fr  instr          comp pc
    vecs.push_back(mk(0, 32'h0000_0013, 1, 0, 32'h0,         0, 0, 32'h0000_0013, 0, 32'h0000_0080));
    vecs.push_back(mk(1, 32'h0000_0013, 1, 0, 32'h0,         1, 1, 32'h0000_0013, 0, 32'h0000_0080));
    vecs.push_back(mk(1, 32'h0010_0093, 1, 0, 32'h0,         1, 1, 32'h0010_0093, 0, 32'h0000_0084));
    vecs.push_back(mk(1, 32'h4501_4481, 1, 0, 32'h0,         1, 1, 32'h0000_4481, 1, 32'h0000_0088));
    vecs.push_back(mk(0, 32'h0,         1, 0, 32'h0,         1, 0, 32'h0000_4501, 1, 32'h0000_008A));
    vecs.push_back(mk(1, 32'h0093_4505, 1, 0, 32'h0,         1, 1, 32'h0000_4505, 1, 32'h0000_008C));
    vecs.push_back(mk(0, 32'h0,         1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_008E));
    vecs.push_back(mk(1, 32'h0000_0113, 0, 0, 32'h0,         1, 0, 32'h0113_0093, 0, 32'h0000_008E));
    vecs.push_back(mk(1, 32'h0000_0113, 0, 0, 32'h0,         1, 0, 32'h0113_0093, 0, 32'h0000_008E));
    vecs.push_back(mk(1, 32'h0000_0113, 0, 0, 32'h0,         1, 0, 32'h0113_0093, 0, 32'h0000_008E));
    vecs.push_back(mk(1, 32'h0000_0113, 1, 0, 32'h0,         1, 1, 32'h0113_0093, 0, 32'h0000_008E));
    vecs.push_back(mk(0, 32'h0,         1, 0, 32'h0,         1, 0, 32'h0000_0000, 1, 32'h0000_0092));
    vecs.push_back(mk(1, 32'h0000_0013, 1, 1, 32'h0000_0102, 0, 0, 32'h0,         0, 32'h0000_0094));
    vecs.push_back(mk(0, 32'h0,         1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0102));
    vecs.push_back(mk(1, 32'h4485_ABCD, 1, 0, 32'h0,         0, 1, 32'h0,         0, 32'h0000_0102));
    vecs.push_back(mk(0, 32'h0,         1, 0, 32'h0,         1, 0, 32'h0000_4485, 1, 32'h0000_0102));
    vecs.push_back(mk(1, 32'h0020_0113, 1, 0, 32'h0,         1, 1, 32'h0020_0113, 0, 32'h0000_0104));
    vecs.push_back(mk(1, 32'h0030_0193, 1, 1, 32'h0000_0200, 0, 0, 32'h0,         0, 32'h0000_0108));
    vecs.push_back(mk(1, 32'h0030_0193, 1, 0, 32'h0,         1, 1, 32'h0030_0193, 0, 32'h0000_0200));
    vecs.push_back(mk(0, 32'h0,         1, 1, 32'h0000_0301, 0, 0, 32'h0,         0, 32'h0000_0204));
    vecs.push_back(mk(0, 32'h0,         1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0300));
    vecs.push_back(mk(0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,         0, 32'h0000_0300));
    vecs.push_back(mk(1, 32'h0000_0013, 1, 0, 32'h0,         1, 1, 32'h0000_0013, 0, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 32'h0,         1, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0000));

    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].fv, vecs[i].rdata, vecs[i].rdy, vecs[i].br, vecs[i].baddr);
      #2;
      check($sformatf("vec%0d instr_valid", i), {31'h0, bus.instr_valid_o}, {31'h0, vecs[i].e_valid});
      check($sformatf("vec%0d fetch_ready", i), {31'h0, bus.fetch_ready_o}, {31'h0, vecs[i].e_fready});
      check($sformatf("vec%0d pc", i), bus.pc_o, vecs[i].e_pc);
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d instr", i), bus.instr_o, vecs[i].e_instr);
        check($sformatf("vec%0d compressed", i), {31'h0, bus.instr_compressed_o}, {31'h0, vecs[i].e_comp});
      end
      @(negedge clk);
    end

    // Enter MIS32 at pc 0, stall, then pull reset asynchronously mid-cycle.
    drive(1'b1, 32'h0093_4505, 1'b1, 1'b0, 32'h0);
    #2;
    check("seq_rst first compressed", bus.instr_o, 32'h0000_4505);
    @(negedge clk);
    drive(1'b1, 32'h0000_0113, 1'b0, 1'b0, 32'h0);
    #2;
    check("seq_rst mis32 instr", bus.instr_o, 32'h0113_0093);
    check("seq_rst mis32 pc", bus.pc_o, 32'h0000_0002);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("seq_rst pc after reset", bus.pc_o, 32'h0000_0080);
    check("seq_rst instr after reset", bus.instr_o, 32'h0000_0113);
    check("seq_rst compressed after reset", {31'h0, bus.instr_compressed_o}, 32'h0);
    check("seq_rst fetch_ready in reset", {31'h0, bus.fetch_ready_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h0000_0113, 1'b1, 1'b0, 32'h0);
    #2;
    check("seq_rst post-reset pop", {31'h0, bus.fetch_ready_o}, 32'h1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    #2;
    check("seq_rst post-reset pc", bus.pc_o, 32'h0000_0084);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
